dispensador_cambio: RTL

DISPENSADOR_CAMBIO -- requirements
Module: dispensador_cambio

---
 rtl/dispensador_pkg.sv | 33 +++
 rtl/dispensador_cambio_if.sv | 26 ++
 rtl/dispensador_timer.sv | 26 ++
 rtl/dispensador_cambio.sv | 96 +++++++++
 4 files changed

// File: rtl/dispensador_pkg.sv
// Shared FSM state encoding and coin denominations for the change dispenser.
// Coin values are expressed in 100-colon units to match the credit/price inputs.
package dispensador_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CALC    = 3'd1,
        REQ500  = 3'd2,
        WAIT500 = 3'd3,
        REQ100  = 3'd4,
        WAIT100 = 3'd5,
        DONE    = 3'd6,
        ERR     = 3'd7
    } estado_e;

    localparam logic [2:0] ST_IDLE    = IDLE;
    localparam logic [2:0] ST_CALC    = CALC;
    localparam logic [2:0] ST_REQ500  = REQ500;
    localparam logic [2:0] ST_WAIT500 = WAIT500;
    localparam logic [2:0] ST_REQ100  = REQ100;
    localparam logic [2:0] ST_WAIT100 = WAIT100;
    localparam logic [2:0] ST_DONE    = DONE;
    localparam logic [2:0] ST_ERR     = ERR;

    localparam int COIN500_UNITS = 5;
    localparam int COIN100_UNITS = 1;

    function automatic logic en_handshake(input logic [2:0] st);
        return (st == ST_REQ500) || (st == ST_WAIT500) ||
               (st == ST_REQ100) || (st == ST_WAIT100);
    endfunction

endpackage

// File: rtl/dispensador_cambio_if.sv
// Dispenser control bus: request/price inputs, coin mechanism 4-phase handshake, status.
// master = vending controller + coin mechanism, slave = dispenser FSM.
interface dispensador_cambio_if #(
    parameter int CREDIT_W = 12
);
    logic                start;
    logic [CREDIT_W-1:0] credito;
    logic [CREDIT_W-1:0] precio;
    logic                coin_ack;
    logic                req500;
    logic                req100;
    logic                busy;
    logic                done;
    logic                err_fondos;
    logic                fault;

    modport master (
        output start, credito, precio, coin_ack,
        input  req500, req100, busy, done, err_fondos, fault
    );

    modport slave (
        input  start, credito, precio, coin_ack,
        output req500, req100, busy, done, err_fondos, fault
    );
endinterface

// File: rtl/dispensador_timer.sv
// Per-state handshake watchdog: expired is high during the LIMIT-th cycle spent in one state.
// Counter restarts on every state change (clr) and whenever no handshake is pending (en low).
module dispensador_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expired
);
    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (!en || clr)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign expired = en && (cnt == W'(LIMIT - 1));
endmodule

// File: rtl/dispensador_cambio.sv
// Change dispenser FSM: greedy 500s then 100s over a 4-phase coin handshake; done 2 cycles after start on zero change.
// Waits on coin_ack indefinitely unless DISPENSADOR_TIMEOUT_EN adds a per-state watchdog that raises sticky fault.
module dispensador_cambio #(
    parameter int CREDIT_W    = 12,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    dispensador_cambio_if.slave bus
);
    import dispensador_pkg::*;

    localparam logic signed [CREDIT_W:0] C500 = (CREDIT_W + 1)'(COIN500_UNITS);
    localparam logic signed [CREDIT_W:0] C100 = (CREDIT_W + 1)'(COIN100_UNITS);

    logic [2:0]              state;
    logic [2:0]              state_nx;
    logic signed [CREDIT_W:0] cambio;
    logic                    timeout;
    logic                    accept;

    assign accept = (state == ST_IDLE) && bus.start;

`ifdef DISPENSADOR_TIMEOUT_EN
    logic fault_q;

    dispensador_timer #(.LIMIT(ACK_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .en      (en_handshake(state)),
        .clr     (state_nx != state),
        .expired (timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            fault_q <= 1'b0;
        else if (timeout)
            fault_q <= 1'b1;
        else if (accept)
            fault_q <= 1'b0;
    end

    assign bus.fault = fault_q;
`else
    assign timeout   = 1'b0;
    assign bus.fault = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (bus.start) state_nx = ST_CALC;
            ST_CALC: begin
                if (cambio[CREDIT_W])    state_nx = ST_ERR;
                else if (cambio >= C500) state_nx = ST_REQ500;
                else if (cambio >= C100) state_nx = ST_REQ100;
                else                     state_nx = ST_DONE;
            end
            ST_REQ500:  if (bus.coin_ack)  state_nx = ST_WAIT500;
            ST_WAIT500: if (!bus.coin_ack) state_nx = ST_CALC;
            ST_REQ100:  if (bus.coin_ack)  state_nx = ST_WAIT100;
            ST_WAIT100: if (!bus.coin_ack) state_nx = ST_CALC;
            ST_DONE:    state_nx = ST_IDLE;
            ST_ERR:     state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
        if (timeout)
            state_nx = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    // Change is committed on the ack edge so a coin is only deducted once it has left.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cambio <= '0;
        else if (accept)
            cambio <= $signed({1'b0, bus.credito}) - $signed({1'b0, bus.precio});
        else if (!timeout && (state == ST_REQ500) && bus.coin_ack)
            cambio <= cambio - C500;
        else if (!timeout && (state == ST_REQ100) && bus.coin_ack)
            cambio <= cambio - C100;
    end

    assign bus.req500     = (state == ST_REQ500);
    assign bus.req100     = (state == ST_REQ100);
    assign bus.busy       = (state != ST_IDLE);
    assign bus.done       = (state == ST_DONE);
    assign bus.err_fondos = (state == ST_ERR);
endmodule
